dnn_dot_engine: RTL

Parametrised, multi-lane fixed-point dot-product engine for the DNN accelerator datapath. It consumes LANES weight/activation pairs per beat over a valid/ready stream and accumulates a vector of `len` elements. At the end it adds a bias, optionally applies ReLU, saturates, and presents one result word on a valid/ready output. It sits between the SDRAM-fed operand fetcher and the layer writer, and generalises the single-lane, single-mode dot product to N lanes, a tail mask, a bias and ReLU/saturation modes.

---
 rtl/dnn_pkg.sv | 44 ++++
 rtl/dnn_mac_lane.sv | 26 ++
 rtl/dnn_dot_engine.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/dnn_pkg.sv
// Shared types and helpers for the multi-lane fixed-point dot-product engine.
package dnn_pkg;

  // Top-level sequencing states of the dot-product engine.
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    OUT
  } dot_state_t;

  // Output selection chosen by the finishing stage.
  typedef enum logic [1:0] {
    SEL_PASS,
    SEL_ZERO,
    SEL_SAT_HI,
    SEL_SAT_LO
  } sat_sel_t;

  // 1.0 in the default Q16.16 format.
  localparam logic [31:0] Q_ONE = 32'h0001_0000;

  // Wide enough for any biased accumulator this engine can produce.
  localparam int SAT_W = 192;

  // Decide how a wide signed result maps onto a dw-bit output word:
  // ReLU clamps negatives to zero, otherwise clip to the signed dw-bit range.
  function automatic sat_sel_t sat_relu(input logic signed [SAT_W-1:0] v,
                                        input int unsigned dw,
                                        input logic relu);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (dw - 1)) - SAT_W'(1);
    lo = -hi - SAT_W'(1);
    if (relu && (v < 0))
      return SEL_ZERO;
    else if (v > hi)
      return SEL_SAT_HI;
    else if (v < lo)
      return SEL_SAT_LO;
    return SEL_PASS;
  endfunction

endpackage

// File: rtl/dnn_mac_lane.sv
// One lane of the engine: registered signed fixed-point multiply, rescaled
// back to the operand's fractional position by an arithmetic right shift.
module dnn_mac_lane #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [DATA_W-1:0]   w,
  input  logic signed [DATA_W-1:0]   a,
  output logic signed [2*DATA_W-1:0] prod
);

  logic signed [2*DATA_W-1:0] full;

  assign full = (2*DATA_W)'(w) * (2*DATA_W)'(a);

  // Register the product; the shift floors toward minus infinity.
  always_ff @(posedge clk) begin
    if (rst)
      prod <= '0;
    else
      prod <= full >>> FRAC_W;
  end

endmodule

// File: rtl/dnn_dot_engine.sv
// Multi-lane fixed-point dot-product engine: operand register, per-lane
// multiply, lane adder, accumulator, then bias/ReLU/saturation into the
// output register, sequenced by a small IDLE/RUN/DRAIN/OUT machine.
module dnn_dot_engine #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int LANES  = 4,
  parameter int LEN_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic [DATA_W-1:0]        bias,
  input  logic                     relu_en,
  output logic                     idle,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*DATA_W-1:0]  in_w,
  input  logic [LANES*DATA_W-1:0]  in_a,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data
);
  import dnn_pkg::*;

  localparam int PROD_W    = 2 * DATA_W;
  localparam int ACC_W     = 2 * DATA_W + LEN_W;
  localparam int LANE_BITS = $clog2(LANES);

  dot_state_t state, state_next;

  logic [LEN_W-1:0]         beats_left;
  logic [LEN_W-1:0]         rem_q;
  logic signed [DATA_W-1:0] bias_q;
  logic                     relu_q;
  logic [1:0]               drain_cnt;
  logic [LEN_W:0]           beats_calc;
  logic                     start_acc;
  logic                     beat;
  logic                     last_beat;

  logic signed [DATA_W-1:0] w_q [LANES];
  logic signed [DATA_W-1:0] a_q [LANES];
  logic signed [PROD_W-1:0] prod [LANES];

  logic signed [ACC_W-1:0]  lane_sum;
  logic signed [ACC_W-1:0]  sum_q;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W:0]    result;
  sat_sel_t                 sel;
  logic [DATA_W-1:0]        final_word;

  assign start_acc  = idle && start;
  assign beat       = in_valid && in_ready;
  assign last_beat  = beat && (beats_left == LEN_W'(1));
  assign beats_calc = {1'b0, len} + (LEN_W+1)'(LANES - 1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic; DRAIN covers the three pipeline stages behind the last beat.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (len == '0) ? DRAIN : RUN;
      RUN:     if (last_beat) state_next = DRAIN;
      DRAIN:   if (drain_cnt == 2'd2) state_next = OUT;
      OUT:     if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded handshake outputs.
  always_comb begin
    idle     = (state == IDLE);
    in_ready = (state == RUN);
  end

  // Operation parameters latched at start, beat countdown and drain timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      beats_left <= '0;
      rem_q      <= '0;
      bias_q     <= '0;
      relu_q     <= 1'b0;
      drain_cnt  <= 2'd0;
    end else begin
      if (start_acc) begin
        beats_left <= LEN_W'(beats_calc >> LANE_BITS);
        rem_q      <= len & LEN_W'(LANES - 1);
        bias_q     <= bias;
        relu_q     <= relu_en;
      end else if (beat) begin
        beats_left <= beats_left - LEN_W'(1);
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
    end
  end

  // Operand stage: capture accepted beats, zero idle cycles and masked tail lanes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (rst || !beat) begin
        w_q[i] <= '0;
        a_q[i] <= '0;
      end else if (last_beat && (rem_q != '0) && (LEN_W'(i) >= rem_q)) begin
        w_q[i] <= '0;
        a_q[i] <= '0;
      end else begin
        w_q[i] <= in_w[i*DATA_W +: DATA_W];
        a_q[i] <= in_a[i*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dnn_mac_lane #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .w    (w_q[i]),
      .a    (a_q[i]),
      .prod (prod[i])
    );
  end

  // Lane adder, sign-extended so the sum can never overflow.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++)
      lane_sum = lane_sum + ACC_W'(prod[i]);
  end

  // Lane-sum register and accumulator; idle stages carry zeros so free-running is safe.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      acc   <= '0;
    end else begin
      sum_q <= lane_sum;
      acc   <= start_acc ? '0 : acc + sum_q;
    end
  end

  // Bias addition and ReLU/saturation choice.
  always_comb begin
    result = (ACC_W+1)'(acc) + (ACC_W+1)'(bias_q);
    sel    = sat_relu(SAT_W'(result), DATA_W, relu_q);
    case (sel)
      SEL_ZERO:   final_word = '0;
      SEL_SAT_HI: final_word = {1'b0, {(DATA_W-1){1'b1}}};
      SEL_SAT_LO: final_word = {1'b1, {(DATA_W-1){1'b0}}};
      default:    final_word = result[DATA_W-1:0];
    endcase
  end

  // Output register: load once on entering OUT, hold until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if ((state == OUT) && !out_valid) begin
      out_valid <= 1'b1;
      out_data  <= final_word;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
